// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: 32-step shift-add MULT and restoring DIV, plus MTHI/MTLO.
// Optional MULT_DIV_UNSIGNED_EN adds MULTU/DIVU (same datapath, sign correction suppressed).
module mult_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [5:0]      alu_op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    localparam logic [5:0] OP_MULT = 6'b011000;
    localparam logic [5:0] OP_DIV  = 6'b011010;
    localparam logic [5:0] OP_MTHI = 6'b010001;
    localparam logic [5:0] OP_MTLO = 6'b010011;
`ifdef MULT_DIV_UNSIGNED_EN
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

    state_t              state_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [2*XLEN-1:0]   acc_d;
    logic [XLEN-1:0]     a_q;
    logic [XLEN-1:0]     b_q;
    logic [CW-1:0]       count_q;
    logic                is_div_q;
    logic                sgn_quo_q;
    logic                sgn_rem_q;
    logic [XLEN-1:0]     hi_q;
    logic [XLEN-1:0]     lo_q;
    logic                done_q;

    logic                is_mul_s;
    logic                is_div_s;
    logic                signed_s;
    logic [XLEN:0]       mul_sum_s;
    logic [XLEN:0]       div_shift_s;
    logic [XLEN:0]       div_diff_s;
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     res_hi_s;
    logic [XLEN-1:0]     res_lo_s;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
        return n ? ({XLEN{1'b0}} - v) : v;
    endfunction

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    // Decode which funct codes start a MULT/DIV and whether they are signed
    always_comb begin
        is_mul_s = 1'b0;
        is_div_s = 1'b0;
        signed_s = 1'b1;
        case (alu_op)
            OP_MULT: is_mul_s = 1'b1;
            OP_DIV:  is_div_s = 1'b1;
`ifdef MULT_DIV_UNSIGNED_EN
            OP_MULTU: begin
                is_mul_s = 1'b1;
                signed_s = 1'b0;
            end
            OP_DIVU: begin
                is_div_s = 1'b1;
                signed_s = 1'b0;
            end
`endif
            default: begin
                is_mul_s = 1'b0;
                is_div_s = 1'b0;
            end
        endcase
    end

    // One iteration: MULT keeps {upper, multiplier} and shifts right; DIV keeps {remainder, dividend} and shifts left
    always_comb begin
        mul_sum_s   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? a_q : {XLEN{1'b0}})};
        div_shift_s = acc_q[2*XLEN-1:XLEN-1];
        div_diff_s  = div_shift_s - {1'b0, b_q};
        if (is_div_q) begin
            if (!div_diff_s[XLEN]) begin
                acc_d = {div_diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
                acc_d = {div_shift_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_d = {mul_sum_s, acc_q[XLEN-1:1]};
        end
    end

    // Sign correction; divide-by-zero forces an all-ones quotient while the remainder naturally equals rs
    always_comb begin
        prod_s = sgn_quo_q ? ({(2*XLEN){1'b0}} - acc_q) : acc_q;
        if (is_div_q) begin
            res_lo_s = (b_q == {XLEN{1'b0}}) ? {XLEN{1'b1}} : cond_neg(acc_q[XLEN-1:0], sgn_quo_q);
            res_hi_s = cond_neg(acc_q[2*XLEN-1:XLEN], sgn_rem_q);
        end else begin
            res_lo_s = prod_s[XLEN-1:0];
            res_hi_s = prod_s[2*XLEN-1:XLEN];
        end
    end

    // Control FSM with registered HI/LO/done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= {(2*XLEN){1'b0}};
            a_q       <= {XLEN{1'b0}};
            b_q       <= {XLEN{1'b0}};
            count_q   <= {CW{1'b0}};
            is_div_q  <= 1'b0;
            sgn_quo_q <= 1'b0;
            sgn_rem_q <= 1'b0;
            hi_q      <= {XLEN{1'b0}};
            lo_q      <= {XLEN{1'b0}};
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start && (is_mul_s || is_div_s)) begin
                        a_q       <= cond_neg(rs_val, signed_s & rs_val[XLEN-1]);
                        b_q       <= cond_neg(rt_val, signed_s & rt_val[XLEN-1]);
                        acc_q     <= {{XLEN{1'b0}}, (is_div_s ? cond_neg(rs_val, signed_s & rs_val[XLEN-1])
                                                              : cond_neg(rt_val, signed_s & rt_val[XLEN-1]))};
                        sgn_quo_q <= signed_s & (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
                        sgn_rem_q <= signed_s & rs_val[XLEN-1];
                        is_div_q  <= is_div_s;
                        count_q   <= {CW{1'b0}};
                        state_q   <= CALC;
                    end else if (start && (alu_op == OP_MTHI)) begin
                        hi_q <= rs_val;
                    end else if (start && (alu_op == OP_MTLO)) begin
                        lo_q <= rs_val;
                    end
                end
                CALC: begin
                    acc_q   <= acc_d;
                    count_q <= count_q + CW'(1);
                    if (count_q == LAST) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    hi_q    <= res_hi_s;
                    lo_q    <= res_lo_s;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: arithmetic reference model with a per-cycle compare, directed literal cases, random traffic.
module tb_mult_div_unit;
    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MTLO  = 6'b010011;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIVU  = 6'b011011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  alu_op = 6'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    mult_div_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .alu_op(alu_op),
        .rs_val(rs_val), .rt_val(rt_val),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] mul_ref(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        if (sgn) return {{32{a[31]}}, a} * {{32{b[31]}}, b};
        else     return {32'd0, a} * {32'd0, b};
    endfunction

    function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        logic signed [63:0] sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic        m_done = 1'b0;
    int          m_cnt = 0;
    logic [63:0] p_res = 64'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hi <= 32'd0; m_lo <= 32'd0; m_done <= 1'b0; m_cnt <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_hi <= p_res[63:32]; m_lo <= p_res[31:0]; m_done <= 1'b1;
                end
            end else if (start) begin
                case (alu_op)
                    OP_MULT: begin p_res <= mul_ref(rs_val, rt_val, 1'b1); m_cnt <= 33; end
                    OP_DIV:  begin p_res <= div_ref(rs_val, rt_val, 1'b1); m_cnt <= 33; end
                    OP_MTHI: m_hi <= rs_val;
                    OP_MTLO: m_lo <= rs_val;
`ifdef MULT_DIV_UNSIGNED_EN
                    OP_MULTU: begin p_res <= mul_ref(rs_val, rt_val, 1'b0); m_cnt <= 33; end
                    OP_DIVU:  begin p_res <= div_ref(rs_val, rt_val, 1'b0); m_cnt <= 33; end
`endif
                    default: ;
                endcase
            end
        end
    end

    // per-cycle compare, away from the active edge
    always @(negedge clk) begin
        chk("busy", busy, m_cnt != 0);
        chk("done", done, m_done);
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #2;
        start = 1'b1; alu_op = op; rs_val = a; rt_val = b;
        @(posedge clk); #2;
        start = 1'b0; rs_val = $urandom; rt_val = $urandom;
    endtask

    task automatic wait_done(output int bc, output bit ok);
        bc = 0; ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (done === 1'b1) ok = 1'b1;
            else if (busy === 1'b1) bc++;
        end
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    logic [5:0] ops [8] = '{OP_MULT, OP_DIV, OP_MTHI, OP_MTLO, OP_MULTU, OP_DIVU, 6'h20, 6'h00};

    initial begin
        int bc;
        bit ok;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);

        start_op(OP_MULT, 32'hFFFF_FFFF, 32'd5);
        wait_done(bc, ok);
        chk("mult_done_seen", ok, 1'b1);
        chk("mult_busy_cycles", bc, 33);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFB);
        @(negedge clk);
        chk("done_one_cycle", done, 1'b0);

        start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(bc, ok);
        chk("div_done_seen", ok, 1'b1);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        start_op(OP_DIV, 32'd100, 32'd0);
        wait_done(bc, ok);
        chk("divz_done_seen", ok, 1'b1);
        chk("divz_busy_cycles", bc, 33);
        chk("divz_lo", lo, 32'hFFFF_FFFF);
        chk("divz_hi", hi, 32'd100);

        start_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(bc, ok);
        chk("ovf_done_seen", ok, 1'b1);
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'd0);
        start = 1'b1; alu_op = OP_MTHI; rs_val = 32'h1234;
        @(posedge clk); #2 start = 1'b0;
        @(negedge clk);
        chk("mthi_in_done_hi", hi, 32'h1234);
        chk("mthi_busy", busy, 1'b0);
        chk("mthi_lo_kept", lo, 32'h8000_0000);

        start_op(OP_MULT, 32'h1234_5678, 32'h100);
        start_op(OP_DIV, 32'd5, 32'd3);
        start_op(OP_MTLO, 32'hAA, 32'd0);
        wait_done(bc, ok);
        chk("intr_done_seen", ok, 1'b1);
        chk("intr_hi", hi, 32'h12);
        chk("intr_lo", lo, 32'h3456_7800);
        chk("intr_lo_not_mtlo", lo != 32'hAA, 1'b1);

`ifdef MULT_DIV_UNSIGNED_EN
        start_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        wait_done(bc, ok);
        chk("multu_done_seen", ok, 1'b1);
        chk("multu_hi", hi, 32'd1);
        chk("multu_lo", lo, 32'hFFFF_FFFE);
`else
        start_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("multu_ignored_busy", busy, 1'b0);
        end
        chk("multu_ignored_hi", hi, 32'h12);
        chk("multu_ignored_lo", lo, 32'h3456_7800);
`endif

        start_op(OP_MULT, 32'd7, 32'd9);
        repeat (9) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        @(posedge clk); #2 rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_no_commit_hi", hi, 32'd0);
        chk("abort_no_commit_lo", lo, 32'd0);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #2;
            if ($urandom_range(0, 399) == 0) rst = 1'b1;
            else rst = 1'b0;
            start  = ($urandom_range(0, 3) == 0);
            alu_op = ops[$urandom_range(0, 7)];
            rs_val = rnd_val();
            rt_val = rnd_val();
        end
        @(posedge clk); #2;
        start = 1'b0; rst = 1'b0;
        repeat (40) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
